// File: rtl/data_mem_dp.sv
// Dual-port data memory: port A read/write with base+offset addressing, port B read-only.
// After reset a hardware sweep initialises every entry; Busy is high until it completes.
module data_mem_dp #(
   parameter int W         = 8,
   parameter int A         = 8,
   parameter int OFFW      = 2,
   parameter int INIT_MODE = 1,
   parameter int REG_RD    = 0
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         WriteEn,
   input  logic [A-1:0] DataAddress,
   input  logic [OFFW-1:0] offset,
   input  logic [W-1:0] DataIn,
   input  logic [A-1:0] RdAddrB,
   output logic [W-1:0] DataOut,
   output logic [W-1:0] DataOutB,
   output logic         Busy,
   output logic         WrDropped
);

   typedef enum logic [0:0] {
      S_INIT = 1'b0,
      S_IDLE = 1'b1
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [A:0]     cnt_r;
   logic [A:0]     cnt_inc_s;
   logic [A-1:0]   ea_s;
   logic           wr_en_s;
   logic [A-1:0]   wr_addr_s;
   logic [W-1:0]   wr_data_s;
   logic [W-1:0]   core_r [2**A];

   function automatic logic [W-1:0] init_value(input logic [A-1:0] idx);
      if (INIT_MODE == 1) begin
         return W'(idx);
      end else begin
         return {W{1'b0}};
      end
   endfunction

   // The offset carry out of the top address bit is deliberately dropped.
   assign ea_s      = DataAddress + A'(offset);
   assign cnt_inc_s = cnt_r + (A+1)'(1);
   assign Busy      = (state_r == S_INIT);

   // Next state: the sweep ends on the edge that writes the last entry.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_INIT: begin
            if (cnt_inc_s[A]) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_INIT;
            end
         end
         S_IDLE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_INIT;
      endcase
   end

   // State, sweep counter and dropped-write pulse.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r   <= S_INIT;
         cnt_r     <= {(A+1){1'b0}};
         WrDropped <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         WrDropped <= (state_r == S_INIT) && WriteEn;
         if (state_r == S_INIT) begin
            cnt_r <= cnt_inc_s;
         end
      end
   end

   // Single write port shared by the init sweep and port A.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = ea_s;
      wr_data_s = DataIn;
      if (Reset) begin
         wr_en_s = 1'b0;
      end else if (state_r == S_INIT) begin
         wr_en_s   = 1'b1;
         wr_addr_s = cnt_r[A-1:0];
         wr_data_s = init_value(cnt_r[A-1:0]);
      end else begin
         wr_en_s = WriteEn;
      end
   end

   // Storage array, no reset: contents come from the sweep.
   always_ff @(posedge Clk) begin
      if (wr_en_s) begin
         core_r[wr_addr_s] <= wr_data_s;
      end
   end

   generate
      if (REG_RD != 0) begin : g_reg_rd
         // Registered reads, write-first: a matching port A write is forwarded.
         always_ff @(posedge Clk) begin
            if (Reset || (state_r == S_INIT)) begin
               DataOut  <= {W{1'b0}};
               DataOutB <= {W{1'b0}};
            end else begin
               DataOut  <= WriteEn ? DataIn : core_r[ea_s];
               DataOutB <= (WriteEn && (RdAddrB == ea_s)) ? DataIn : core_r[RdAddrB];
            end
         end
      end else begin : g_comb_rd
         // Combinational reads show pre-edge contents during a same-cycle write.
         always_comb begin
            DataOut  = {W{1'b0}};
            DataOutB = {W{1'b0}};
            if (state_r == S_INIT) begin
               DataOut  = {W{1'b0}};
               DataOutB = {W{1'b0}};
            end else begin
               DataOut  = core_r[ea_s];
               DataOutB = core_r[RdAddrB];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_dp.sv
// Randomised and directed bench for data_mem_dp: three instances (combinational,
// registered, zero-fill) share stimulus and are compared against a behavioural model.
module tb_data_mem_dp;

   logic       Clk;
   logic       Reset;
   logic       WriteEn;
   logic [7:0] DataAddress;
   logic [1:0] offset;
   logic [7:0] DataIn;
   logic [7:0] RdAddrB;

   logic [7:0] c_dout, c_doutb, r_dout, r_doutb, z_dout, z_doutb;
   logic       c_busy, r_busy, z_busy, c_wd, r_wd, z_wd;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state.
   logic [7:0] mem1 [256];
   logic [7:0] mem0 [256];
   int         swept;
   bit         m_busy;
   logic       m_wd;
   logic [7:0] m_ra, m_rb;
   bit         started;

   data_mem_dp #(.W(8), .A(8), .OFFW(2), .INIT_MODE(1), .REG_RD(0)) u_comb (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .DataAddress(DataAddress),
      .offset(offset), .DataIn(DataIn), .RdAddrB(RdAddrB),
      .DataOut(c_dout), .DataOutB(c_doutb), .Busy(c_busy), .WrDropped(c_wd));

   data_mem_dp #(.W(8), .A(8), .OFFW(2), .INIT_MODE(1), .REG_RD(1)) u_reg (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .DataAddress(DataAddress),
      .offset(offset), .DataIn(DataIn), .RdAddrB(RdAddrB),
      .DataOut(r_dout), .DataOutB(r_doutb), .Busy(r_busy), .WrDropped(r_wd));

   data_mem_dp #(.W(8), .A(8), .OFFW(2), .INIT_MODE(0), .REG_RD(0)) u_zero (
      .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .DataAddress(DataAddress),
      .offset(offset), .DataIn(DataIn), .RdAddrB(RdAddrB),
      .DataOut(z_dout), .DataOutB(z_doutb), .Busy(z_busy), .WrDropped(z_wd));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int eff_addr();
      return (int'(DataAddress) + int'(offset)) % 256;
   endfunction

   // Behavioural effect of one rising edge, using the inputs held across it.
   task automatic model_edge();
      int ea;
      ea = eff_addr();
      if (Reset) begin
         swept  = 0;
         m_busy = 1'b1;
         m_wd   = 1'b0;
         m_ra   = 8'h00;
         m_rb   = 8'h00;
      end else if (m_busy) begin
         mem1[swept] = 8'(swept);
         mem0[swept] = 8'h00;
         swept++;
         if (swept == 256) m_busy = 1'b0;
         m_wd = WriteEn;
         m_ra = 8'h00;
         m_rb = 8'h00;
      end else begin
         m_ra = WriteEn ? DataIn : mem1[ea];
         m_rb = (WriteEn && (int'(RdAddrB) == ea)) ? DataIn : mem1[RdAddrB];
         if (WriteEn) begin
            mem1[ea] = DataIn;
            mem0[ea] = DataIn;
         end
         m_wd = 1'b0;
      end
      started = 1'b1;
   endtask

   task automatic check_all();
      int ea;
      ea = eff_addr();
      check_eq("c_busy", 32'(c_busy), 32'(m_busy));
      check_eq("r_busy", 32'(r_busy), 32'(m_busy));
      check_eq("z_busy", 32'(z_busy), 32'(m_busy));
      check_eq("c_wrdrop", 32'(c_wd), 32'(m_wd));
      check_eq("r_wrdrop", 32'(r_wd), 32'(m_wd));
      check_eq("c_dout", 32'(c_dout), m_busy ? 32'd0 : 32'(mem1[ea]));
      check_eq("c_doutb", 32'(c_doutb), m_busy ? 32'd0 : 32'(mem1[RdAddrB]));
      check_eq("z_dout", 32'(z_dout), m_busy ? 32'd0 : 32'(mem0[ea]));
      check_eq("z_doutb", 32'(z_doutb), m_busy ? 32'd0 : 32'(mem0[RdAddrB]));
      check_eq("r_dout", 32'(r_dout), 32'(m_ra));
      check_eq("r_doutb", 32'(r_doutb), 32'(m_rb));
   endtask

   // Check with fresh inputs, take one edge, check again with the same inputs.
   task automatic step();
      #1;
      if (started) check_all();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      #1;
      check_all();
   endtask

   task automatic set_in(input logic we, input logic [7:0] da, input logic [1:0] off,
                         input logic [7:0] din, input logic [7:0] rb);
      WriteEn = we; DataAddress = da; offset = off; DataIn = din; RdAddrB = rb;
   endtask

   task automatic run_sweep(input string tag);
      int n;
      n = 0;
      while (n < 400 && c_busy !== 1'b0) begin
         step();
         n++;
      end
      check_eq({tag, "_len"}, 32'(n), 32'd256);
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 256; i++) begin
         set_in(1'b0, 8'(i), 2'd0, 8'h00, 8'(i));
         step();
         check_eq({tag, "_core"}, 32'(c_doutb), 32'(i));
         check_eq({tag, "_zero"}, 32'(z_doutb), 32'd0);
      end
   endtask

   initial begin
      int n;
      started = 1'b0;
      swept   = 0;
      m_busy  = 1'b1;
      m_wd    = 1'b0;
      m_ra    = 8'h00;
      m_rb    = 8'h00;
      Reset   = 1'b1;
      set_in(1'b0, 8'h00, 2'd0, 8'h00, 8'h00);

      step();
      step();
      check_eq("rst_busy", 32'(c_busy), 32'd1);
      check_eq("rst_wrdrop", 32'(c_wd), 32'd0);
      check_eq("rst_rdout", 32'(r_doutb), 32'd0);

      // Sweep with a dropped write on the tenth edge.
      Reset = 1'b0;
      n = 0;
      while (n < 400 && c_busy !== 1'b0) begin
         set_in(n == 9, 8'h05, 2'd0, 8'hAA, 8'h05);
         step();
         n++;
         if (n == 10) check_eq("drop_pulse", 32'(c_wd), 32'd1);
         if (n == 11) check_eq("drop_clear", 32'(c_wd), 32'd0);
         if (n < 256) check_eq("busy_dout", 32'(c_dout), 32'd0);
      end
      check_eq("sweep_len", 32'(n), 32'd256);
      read_all("init");

      // Offset wraps past the top of the address space.
      set_in(1'b1, 8'hFE, 2'd3, 8'h5C, 8'h00);
      step();
      set_in(1'b0, 8'h00, 2'd0, 8'h00, 8'h01);
      step();
      check_eq("wrap_c", 32'(c_doutb), 32'h5C);
      check_eq("wrap_r", 32'(r_doutb), 32'h5C);

      // Read-during-write on the same address.
      set_in(1'b1, 8'h10, 2'd0, 8'h77, 8'h10);
      #1;
      check_eq("rdw_old", 32'(c_dout), 32'h10);
      step();
      check_eq("rdw_new", 32'(c_dout), 32'h77);
      check_eq("byp_b", 32'(r_doutb), 32'h77);
      check_eq("byp_a", 32'(r_dout), 32'h77);
      set_in(1'b1, 8'h12, 2'd0, 8'h66, 8'h11);
      step();
      check_eq("nobyp_b", 32'(r_doutb), 32'h11);

      // Random traffic, biased towards same-address reads on port B.
      for (int k = 0; k < 400; k++) begin
         set_in(1'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
         if ($urandom_range(3, 0) == 0) RdAddrB = DataAddress + 8'(offset);
         step();
      end

      // Reset 100 edges into a sweep, then a full sweep must restore every entry.
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int k = 0; k < 100; k++) begin
         set_in(1'($urandom), 8'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
         step();
      end
      Reset = 1'b1;
      step();
      step();
      check_eq("rst2_busy", 32'(c_busy), 32'd1);
      Reset = 1'b0;
      set_in(1'b0, 8'h00, 2'd0, 8'h00, 8'h00);
      run_sweep("resweep");
      read_all("final");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_mem_dp.md
Name: data_mem_dp

Overview:
- Parametrised successor to the single-port data memory: W-bit by 2**A-deep storage with one write/read port (port A, base+offset addressing) and an independent second read port (port B).
- Memory initialisation is a multi-cycle hardware sweep that starts after reset, not a single-cycle reset loop; a Busy flag tells the core when the memory is usable.
- Read latency is selectable (combinational or registered, write-first bypass). Sits between the CPU load/store path and a debug/DMA read-back path.

Parameters:
- W, 8, data width in bits.
- A, 8, address width; depth = 2**A.
- OFFW, 2, width of the offset input.
- INIT_MODE, 1; 0 = zero-fill, 1 = Core[i] = i[W-1:0] (i zero-extended if W > A).
- REG_RD, 0; 0 = combinational reads, 1 = registered reads (1-cycle latency).

Ports:
- Clk  in  1  single clock, all state on rising edge.
- Reset  in  1  synchronous, active-high.
- WriteEn  in  1  port A write strobe.
- DataAddress  in  A  port A base address.
- offset  in  OFFW  port A offset, zero-extended and added to DataAddress.
- DataIn  in  W  port A write data.
- RdAddrB  in  A  port B read address.
- DataOut  out  W  port A read data.
- DataOutB  out  W  port B read data.
- Busy  out  1  high while the init sweep runs.
- WrDropped  out  1  registered one-cycle pulse: a write was rejected because Busy was high.

Behaviour:
- Effective address EA = (DataAddress + zext(offset)) mod 2**A. Carry is discarded, so 8'hFF + 2 = 8'h01.
- FSM states are INIT and IDLE. A 2**A-wide sweep counter cnt has A+1 bits.
- Reset high: state <= INIT, cnt <= 0, WrDropped <= 0, registered read outputs <= 0. No memory write occurs while Reset is high.
- INIT with Reset low: on each edge write Core[cnt] <= init value, then cnt++. On the edge that writes Core[2**A-1], state <= IDLE.
  - Busy = (state == INIT), so Busy is 1 from reset through exactly 2**A edges after Reset deasserts.
- Reset asserted mid-sweep: restart from cnt = 0. Entries already written stay written and are overwritten again.
- IDLE: if WriteEn, Core[EA] <= DataIn on the edge.
- INIT with WriteEn: no write to Core. WrDropped <= 1 on that edge; otherwise WrDropped <= 0.
- Reads while Busy: DataOut and DataOutB are forced to 0. With REG_RD=1 the registers load 0.
- REG_RD=0:
  - DataOut = Core[EA] and DataOutB = Core[RdAddrB], combinationally.
  - A same-cycle write shows old data until the edge, new data afterwards.
- REG_RD=1:
  - Both outputs are registered from the current cycle's addresses.
  - If WriteEn is high in IDLE and the read address equals EA, the register captures DataIn (write-first bypass). This applies to each port independently.
- Port B never writes. Simultaneous A write and B read of the same address follow the read-during-write rule above.
- No X on outputs after the first Reset edge. Core contents are undefined before the first completed sweep.

Test Plan:
- Reset for 2 cycles, release, count edges -> Busy=1 for exactly 256 edges then 0. Core[i]==i for all i (INIT_MODE=1). With INIT_MODE=0, all 0.
- Reset, then WriteEn=1 at cycle 10 of the sweep, DataAddress=8'h05, DataIn=8'hAA -> WrDropped pulses 1 cycle later. After the sweep Core[5]==8'h05. DataOut==0 while Busy.
- After init: DataAddress=8'hFE, offset=3, DataIn=8'h5C, WriteEn=1 -> Core[8'h01]==8'h5C. With RdAddrB=8'h01, DataOutB==8'h5C the following cycle.
- REG_RD=1: write 8'h77 to EA=8'h10 while RdAddrB=8'h10 -> DataOutB==8'h77 on the next cycle (bypass). A read of 8'h11 in the same cycle returns 8'h11.
- REG_RD=0: same write -> DataOut shows 8'h10 before the edge and 8'h77 after it.
- Reset at sweep cycle 100 -> cnt restarts. Busy stays high for 256 further edges after release. Final Core[i]==i.
